// File: rtl/counter_pkg.sv
// counter_pkg: shared types, width helpers and parameter checks for counter_updown_mod
package counter_pkg;
  typedef enum logic {DIR_DOWN, DIR_UP} count_dir_e;
  function automatic int pre_width(input int unsigned prescale);
    return prescale <= 2 ? 1 : $clog2(prescale);
  endfunction
  function automatic bit params_ok(input int width, input longint unsigned max_val,
                                   input int unsigned prescale);
    return width >= 2 && width <= 32 && max_val >= 1 &&
           max_val <= (64'd1 << width) - 1 && prescale >= 1 && prescale <= 65536;
  endfunction
endpackage

// File: rtl/tick_prescaler.sv
// tick_prescaler: emits one tick every PRESCALE enabled cycles
module tick_prescaler
  import counter_pkg::*;
#(
  parameter int unsigned PRESCALE = 1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clr,
  input  logic en,
  output logic tick
);
  if (PRESCALE == 1) begin : g_direct
    assign tick = en;
  end else begin : g_count
    localparam int PW = pre_width(PRESCALE);
    localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);
    logic [PW-1:0] pre;
    assign tick = en && pre == LAST;
    always_ff @(posedge clk or negedge reset_n)
      if (!reset_n) pre <= '0;
      else pre <= clr || tick ? '0 : en ? pre + 1'b1 : pre;
  end
endmodule

// File: rtl/counter_updown_mod.sv
// counter_updown_mod: up/down modulo counter with clear, load, prescaler,
// terminal-count pulse, sticky overflow and compare match
module counter_updown_mod
  import counter_pkg::*;
#(
  parameter int          WIDTH    = 8,
  parameter int unsigned MAX_VAL  = (1 << WIDTH) - 1,
  parameter int unsigned PRESCALE = 1,
  parameter bit          SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             clear,
  input  logic             load,
  input  logic [WIDTH-1:0] load_data,
  input  logic             en,
  input  logic             up,
  input  logic [WIDTH-1:0] cmp_val,
  input  logic             ovf_clr,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             cmp_match,
  output logic             ovf_sticky
);
  if (!params_ok(WIDTH, longint'(MAX_VAL), PRESCALE)) begin : g_bad_params
    $error("counter_updown_mod: illegal parameter combination");
  end
  localparam logic [WIDTH-1:0] MAX = WIDTH'(MAX_VAL);
  logic tick, at_max, at_min, wrap, tc_nxt;
  logic [WIDTH-1:0] nxt, ld_val;
  count_dir_e dir;
  tick_prescaler #(.PRESCALE(PRESCALE)) u_pre (
    .clk(clk), .reset_n(reset_n), .clr(clear || load), .en(en), .tick(tick)
  );
  assign dir    = count_dir_e'(up);
  assign at_max = count == MAX;
  assign at_min = count == '0;
  assign wrap   = tick && (dir == DIR_UP ? at_max : at_min);
  assign ld_val = load_data > MAX ? MAX : load_data;
  // bound checks come before +/-1, so the arithmetic never leaves WIDTH bits
  always_comb begin
    nxt = clear ? '0 : load ? ld_val : !tick ? count :
          dir == DIR_UP ? (at_max ? (SATURATE ? MAX : '0) : count + 1'b1) :
                          (at_min ? (SATURATE ? '0 : MAX) : count - 1'b1);
    tc_nxt = !clear && !load && wrap;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      count      <= '0;
      tc         <= 1'b0;
      ovf_sticky <= 1'b0;
    end else begin
      count      <= nxt;
      tc         <= tc_nxt;
      ovf_sticky <= tc_nxt || (ovf_sticky && !ovf_clr);
    end
  assign cmp_match = count == cmp_val;
endmodule
